// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, reset PC, halt word, instruction fields and fetch states.
package cpu_pkg;

   localparam int unsigned BITS_DATA = 32;
   localparam int unsigned BITS_ADDR = 16;
   localparam logic [BITS_ADDR-1:0] RESET_PC = 16'h0000;
   localparam logic [BITS_DATA-1:0] HLT_WORD = 32'hFFFFFFFF;

   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 27;
   localparam int unsigned REG_A_MSB  = 26;
   localparam int unsigned REG_A_LSB  = 24;
   localparam int unsigned REG_B_MSB  = 23;
   localparam int unsigned REG_B_LSB  = 16;
   localparam int unsigned IMM_MSB    = 15;
   localparam int unsigned IMM_LSB    = 0;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

   function automatic logic [4:0] get_opcode(input logic [BITS_DATA-1:0] word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter register: load has priority over increment; increment wraps at the top.
module fetch_pc_counter #(
   parameter int unsigned           BITS_ADDR = 16,
   parameter logic [BITS_ADDR-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [BITS_ADDR-1:0] load_pc,
   input  logic                 inc,
   output logic [BITS_ADDR-1:0] pc
);

   logic [BITS_ADDR-1:0] pc_d, pc_q;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_pc;
      end else if (inc) begin
         pc_d = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_mem_ctrl.sv
// Instruction fetch and memory port arbiter: data accesses win the port, fetch fills a
// single registered instruction slot with a valid/ready handshake.
module fetch_mem_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned           BITS_DATA = cpu_pkg::BITS_DATA,
   parameter int unsigned           BITS_ADDR = cpu_pkg::BITS_ADDR,
   parameter logic [BITS_ADDR-1:0] RESET_PC  = cpu_pkg::RESET_PC,
   parameter logic [BITS_DATA-1:0] HLT_WORD  = cpu_pkg::HLT_WORD
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [BITS_ADDR-1:0] mem_address,
   output logic [BITS_DATA-1:0] mem_wdata,
   output logic                 mem_write,
   input  logic [BITS_DATA-1:0] mem_rdata,
   output logic [BITS_DATA-1:0] instr,
   output logic [BITS_ADDR-1:0] instr_pc,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   input  logic                 redirect,
   input  logic [BITS_ADDR-1:0] redirect_pc,
   input  logic                 dreq,
   input  logic                 dwe,
   input  logic [BITS_ADDR-1:0] daddr,
   input  logic [BITS_DATA-1:0] dwdata,
   output logic [BITS_DATA-1:0] drdata,
   output logic                 dack,
   output logic                 halted
);

   state_e               state_d, state_q;
   logic [BITS_DATA-1:0] instr_d, instr_q;
   logic [BITS_ADDR-1:0] instr_pc_d, instr_pc_q;
   logic                 instr_valid_d, instr_valid_q;
   logic [BITS_ADDR-1:0] pc;
   logic                 running, redirect_en, fetch_en, is_hlt;

   assign running     = (state_q == RUN);
   assign redirect_en = redirect & running;
   assign fetch_en    = running & ~dreq & ~redirect & (~instr_valid_q | instr_ready);
   assign is_hlt      = (mem_rdata == HLT_WORD);

   // Write enable is gated by reset so a held store cannot corrupt memory during reset.
   always_comb begin
      mem_address = dreq ? daddr : pc;
      mem_write   = dreq & dwe & ~reset;
      mem_wdata   = dwdata;
      dack        = dreq;
      drdata      = mem_rdata;
   end

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      if (redirect_en) begin
         instr_valid_d = 1'b0;
      end else if (fetch_en && is_hlt) begin
         state_d       = HALT;
         instr_valid_d = 1'b0;
      end else if (fetch_en) begin
         instr_d       = mem_rdata;
         instr_pc_d    = pc;
         instr_valid_d = 1'b1;
      end else if (instr_valid_q && instr_ready) begin
         instr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   fetch_pc_counter #(
      .BITS_ADDR(BITS_ADDR),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk    (clk),
      .reset  (reset),
      .load   (redirect_en),
      .load_pc(redirect_pc),
      .inc    (fetch_en & ~is_hlt),
      .pc     (pc)
   );

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Bench for fetch_mem_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_fetch_mem_ctrl;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        dreq;
   logic        dwe;
   logic [15:0] daddr;
   logic [31:0] dwdata;
   logic [31:0] drdata;
   logic        dack;
   logic        halted;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem     [65536];
   logic [31:0] ref_mem [65536];

   // Behavioural view of the fetch unit.
   logic [15:0] m_pc, m_ipc;
   logic [31:0] m_instr;
   bit          m_valid, m_halt;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_address];

   fetch_mem_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .mem_address(mem_address),
      .mem_wdata  (mem_wdata),
      .mem_write  (mem_write),
      .mem_rdata  (mem_rdata),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .dreq       (dreq),
      .dwe        (dwe),
      .daddr      (daddr),
      .dwdata     (dwdata),
      .drdata     (drdata),
      .dack       (dack),
      .halted     (halted)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc    = RESET_PC;
      m_ipc   = '0;
      m_instr = '0;
      m_valid = 0;
      m_halt  = 0;
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic do_reset();
      reset = 1'b1;
      dreq  = 1'b1;
      dwe   = 1'b1;
      daddr = 16'h8100;
      #1;
      check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("rst_halted", {31'b0, halted}, 32'd0);
      check_eq("rst_mem_write", {31'b0, mem_write}, 32'd0);
      dreq = 1'b0;
      dwe  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // One clock cycle: apply inputs, check outputs, perform memory write, advance the model.
   task automatic cycle(input bit rdy, input bit rd, input logic [15:0] rpc, input bit dq,
                        input bit we, input logic [15:0] da, input logic [31:0] dw);
      logic [31:0] word;
      instr_ready = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      dreq        = dq;
      dwe         = we;
      daddr       = da;
      dwdata      = dw;
      #3;
      check_eq("mem_address", {16'b0, mem_address}, {16'b0, dq ? da : m_pc});
      check_eq("mem_write", {31'b0, mem_write}, {31'b0, dq & we});
      check_eq("dack", {31'b0, dack}, {31'b0, dq});
      if (dq && !we) check_eq("drdata", drdata, ref_mem[da]);
      if (dq && we) check_eq("mem_wdata", mem_wdata, dw);
      check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      check_eq("halted", {31'b0, halted}, {31'b0, m_halt});
      if (m_valid) begin
         check_eq("instr", instr, m_instr);
         check_eq("instr_pc", {16'b0, instr_pc}, {16'b0, m_ipc});
      end
      @(negedge clk);
      if (mem_write) mem[mem_address] = mem_wdata;
      word = ref_mem[m_pc];
      if (dq && we) ref_mem[da] = dw;
      if (!m_halt && rd) begin
         m_pc    = rpc;
         m_valid = 0;
      end else if (!m_halt && !dq && (!m_valid || rdy)) begin
         if (word == HLT_WORD) begin
            m_halt  = 1;
            m_valid = 0;
         end else begin
            m_instr = word;
            m_ipc   = m_pc;
            m_pc    = m_pc + 16'd1;
            m_valid = 1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rdy);
      cycle(rdy, 0, 16'h0, 0, 0, 16'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] w;
      reset       = 1'b1;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      dreq        = 1'b0;
      dwe         = 1'b0;
      daddr       = '0;
      dwdata      = '0;
      for (int i = 0; i < 65536; i++) begin
         w = $urandom;
         if (w == HLT_WORD || ($urandom % 128) == 0) w = (($urandom % 128) == 0) ? HLT_WORD : 32'h1;
         mem[i] = w;
      end
      mem[0] = 32'h0900000C;
      mem[1] = 32'h09010001;
      mem[2] = 32'h09020001;
      mem[3] = 32'h09030001;
      mem[4] = HLT_WORD;
      for (int i = 5; i < 16; i++) mem[i] = 32'h0A000000 | i;
      mem[16'hFFFF] = 32'h0BFFFFFF;
      for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
      model_reset();
      @(posedge clk);
      #1;

      // Sequential fetch, stall, store/load, halt.
      do_reset();
      idle(1);
      check_eq("tp_pc0", {16'b0, instr_pc}, 32'd0);
      check_eq("tp_w0", instr, 32'h0900000C);
      repeat (3) idle(0);
      check_eq("tp_hold_pc", {16'b0, instr_pc}, 32'd0);
      check_eq("tp_hold_addr", {16'b0, mem_address}, 32'd1);
      idle(1);
      check_eq("tp_resume", {16'b0, instr_pc}, 32'd1);
      idle(1);
      idle(1);
      check_eq("tp_pc3", {16'b0, instr_pc}, 32'd3);
      cycle(1, 0, 16'h0, 1, 1, 16'h8000, 32'h1);
      dwe = 1'b0;
      #1;
      check_eq("tp_load", drdata, 32'h1);
      cycle(1, 0, 16'h0, 1, 0, 16'h8000, 32'h0);
      idle(1);
      check_eq("tp_halted", {31'b0, halted}, 32'd1);
      check_eq("tp_halt_addr", {16'b0, mem_address}, 32'd4);
      cycle(1, 0, 16'h0, 1, 0, 16'h0002, 32'h0);
      cycle(1, 1, 16'h0005, 0, 0, 16'h0, 32'h0);
      idle(1);

      // Restart after reset; redirect coinciding with an accept.
      do_reset();
      idle(1);
      check_eq("tp_restart", {16'b0, instr_pc}, 32'd0);
      cycle(1, 1, 16'h0006, 0, 0, 16'h0, 32'h0);
      idle(1);
      check_eq("tp_redir_pc", {16'b0, instr_pc}, 32'd6);

      // PC wrap.
      cycle(1, 1, 16'hFFFF, 0, 0, 16'h0, 32'h0);
      idle(1);
      check_eq("tp_wrap_hi", {16'b0, instr_pc}, 32'h0000FFFF);
      idle(0);
      idle(1);
      check_eq("tp_wrap_lo", {16'b0, instr_pc}, 32'd0);

      // Asynchronous reset while an instruction is valid.
      do_reset();

      // Random traffic.
      for (int ep = 0; ep < 8; ep++) begin
         do_reset();
         for (int c = 0; c < 400; c++) begin
            logic [15:0] rpc;
            rpc = (($urandom % 4) == 0) ? 16'hFFFE + 16'($urandom % 2) : 16'($urandom);
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, rpc, ($urandom % 5) == 0,
                  $urandom % 2, 16'($urandom), $urandom);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_mem_ctrl.md
# fetch_mem_ctrl

Owns the single read/write port of the 32-bit × 64Ki-word main memory (asynchronous read, write sampled on the falling clock edge). It fetches instructions sequentially into a registered instruction slot with a valid/ready handshake toward the control unit, and arbitrates the port between instruction fetch and load/store requests from execute. It also handles branch redirects and the halt word.

## Interface
- BITS_DATA, 32, data word width
- BITS_ADDR, 16, word address width
- RESET_PC, 16'h0000, PC value after reset
- HLT_WORD, 32'hFFFFFFFF, instruction word that halts fetch
---
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_address  out  BITS_ADDR  address to memory
- mem_wdata  out  BITS_DATA  write data to memory data input
- mem_write  out  1  write enable to memory (sampled by memory on falling edge)
- mem_rdata  in  BITS_DATA  memory asynchronous read data
- instr  out  BITS_DATA  registered instruction word
- instr_pc  out  BITS_ADDR  address the instruction was fetched from
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr_ready  in  1  consumer accepts instr this cycle
- redirect  in  1  branch taken; restart fetch at redirect_pc
- redirect_pc  in  BITS_ADDR  branch target
- dreq  in  1  data access request (single cycle)
- dwe  in  1  1 = store, 0 = load
- daddr  in  BITS_ADDR  data address
- dwdata  in  BITS_DATA  store data
- drdata  out  BITS_DATA  load data (combinational)
- dack  out  1  data access performed this cycle
- halted  out  1  HLT_WORD fetched; fetch stopped

## Operation
- States: RUN, HALT. Registers: pc, instr, instr_pc, instr_valid.
- Port mux, combinational: dreq=1 → mem_address=daddr, mem_write=dwe, mem_wdata=dwdata, dack=1, drdata=mem_rdata; otherwise mem_address=pc, mem_write=0. Data always has priority, in both states.
- fetch_en = (state==RUN) & !dreq & !redirect & (!instr_valid | instr_ready).
- Rising edge, priority order:
  - redirect & state==RUN: pc←redirect_pc, instr_valid←0. A data access in the same cycle still completes.
  - fetch_en & mem_rdata==HLT_WORD: state←HALT, instr_valid←0, pc unchanged. The HLT word is never presented.
  - fetch_en: instr←mem_rdata, instr_pc←pc, pc←pc+1 (mod 2^BITS_ADDR; 16'hFFFF wraps to 0), instr_valid←1.
  - else instr_valid & instr_ready: instr_valid←0.
- HALT: only reset exits. redirect is ignored. Loads and stores are still served.
- halted = (state==HALT).

## Timing
- Reset (asynchronous): pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, state=RUN, halted=0. mem_write is forced to 0 while reset=1.
- Fetch latency: 1 cycle from pc presented to instr_valid. Throughput is 1 instruction/cycle when instr_ready=1 and dreq=0.
- Each data access costs exactly one fetch cycle. dack and drdata are valid in the same cycle as dreq.
- Stores: dreq, dwe, daddr and dwdata must come from rising-edge registers so they are stable across the falling edge where memory captures them. mem_address changes only after rising edges.
- Handshake: instr and instr_pc stay stable while instr_valid=1 & instr_ready=0. instr_ready is ignored while instr_valid=0.
- Redirect on the same edge as an accept: the accept completes and the next fetch uses redirect_pc. The stale prefetch is never presented.
- dreq held high continuously starves fetch. This is legal; no fairness requirement.

## Structure
- Shared package cpu_pkg holds:
  - BITS_DATA, BITS_ADDR, HLT_WORD, RESET_PC
  - opcode field [31:27], reg field [26:24], reg field [23:16], immediate [15:0]
  - state enum {RUN, HALT}
- One sub-module: fetch_pc_counter (pc register with load, increment, wrap). Everything else is inline.

## Test plan
- Reset, mem[0..3]=0x0900000C, 0x09010001, 0x09020001, 0x09030001, instr_ready=1 → instr_valid rises after first edge; instr_pc 0,1,2,3 on consecutive cycles with matching words.
- instr_ready=0 for 3 cycles after first valid → instr=0x0900000C and instr_pc=0 held; pc=1 and mem_address=1 held; resumes with instr_pc=1.
- dreq=1, dwe=1, daddr=0x8000, dwdata=0x1 mid-stream → mem_write=1 and dack=1 that cycle; one fetch bubble; next-cycle load of 0x8000 returns drdata=0x1.
- redirect=1, redirect_pc=0x0006 on the same edge as an accept → next instr_pc=6; no word from the old path appears.
- mem[4]=0xFFFFFFFF → after instr_pc=3 is accepted, instr_valid=0 and halted=1; mem_address holds 4; a load in HALT is acked; reset clears halted and fetch restarts at 0.
- redirect_pc=0xFFFF → instr_pc 0xFFFF then 0x0000. Asserting reset mid-fetch drops instr_valid immediately, without waiting for a clock edge.
